// File: rtl/coherence_bus_ctrl.sv
// Shared-bus responder and snoop hub for a set of coherent caches.
// Grants the bus round-robin, serves line reads and flushes from an internal
// line-wide memory, and fans coherence broadcasts out as snoops to the peers.
module coherence_bus_ctrl #(
    parameter int NUM_CACHES     = 2,
    parameter int ADDR_BUS_WIDTH = 32,
    parameter int LOG2_LINE_SIZE = 2,
    parameter int MEM_LINES      = 256,
    parameter int MEM_LAT        = 2,
    localparam int LINE_W        = 8 << LOG2_LINE_SIZE
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_CACHES-1:0]              hreq,
    output logic [NUM_CACHES-1:0]              hgrant,
    output logic [NUM_CACHES-1:0]              hready,
    input  logic [NUM_CACHES*ADDR_BUS_WIDTH-1:0] haddr,
    input  logic [NUM_CACHES-1:0]              hwrite,
    input  logic [NUM_CACHES*LINE_W-1:0]       hwdata,
    output logic [LINE_W-1:0]                  hrdata,
    input  logic [NUM_CACHES*3-1:0]            broadcast,
    output logic [NUM_CACHES-1:0]              other_copies,
    output logic [NUM_CACHES-1:0]              snoop_valid,
    output logic [ADDR_BUS_WIDTH-1:0]          saddr,
    output logic [1:0]                         sn_state,
    input  logic [NUM_CACHES*2-1:0]            sc_state,
    input  logic [NUM_CACHES*LINE_W-1:0]       sdata
);

    localparam int CW    = (NUM_CACHES > 1) ? $clog2(NUM_CACHES) : 1;
    localparam int IDX_W = (MEM_LINES > 1) ? $clog2(MEM_LINES) : 1;
    localparam int CNT_W = $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

    localparam logic [2:0] BC_RD  = 3'd1;
    localparam logic [2:0] BC_RTM = 3'd2;
    localparam logic [2:0] BC_IVD = 3'd3;
    localparam logic [2:0] BC_ISL = 3'd4;

    localparam logic [1:0] ST_INVALID  = 2'd0;
    localparam logic [1:0] ST_SHARED   = 2'd1;
    localparam logic [1:0] ST_MODIFIED = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GRANT = 3'd1,
        S_ADDR  = 3'd2,
        S_SNOOP = 3'd3,
        S_DATA  = 3'd4,
        S_WDATA = 3'd5,
        S_RESP  = 3'd6
    } state_t;

    state_t                    state_r;
    logic [CW-1:0]             m_r;
    logic [CW-1:0]             rr_r;
    logic [ADDR_BUS_WIDTH-1:0] addr_r;
    logic [2:0]                bc_r;
    logic                      isl_r;
    logic                      owner_valid_r;
    logic [LINE_W-1:0]         owner_data_r;
    logic [CNT_W-1:0]          cnt_r;
    logic [LINE_W-1:0]         mem_r [MEM_LINES];

    logic [CW-1:0]             pick_s;
    logic [CW-1:0]             cand_s;
    logic                      found_s;
    logic [NUM_CACHES-1:0]     holders_s;
    logic                      own_found_s;
    logic [LINE_W-1:0]         own_data_s;
    logic [IDX_W-1:0]          idx_s;
    logic                      mem_we_s;
    logic [LINE_W-1:0]         mem_wdata_s;
    logic [ADDR_BUS_WIDTH-1:0] haddr_m_s;
    logic [2:0]                bc_m_s;
    logic [LINE_W-1:0]         hwdata_m_s;

    function automatic logic [NUM_CACHES-1:0] onehot(input logic [CW-1:0] i);
        onehot = NUM_CACHES'(1) << i;
    endfunction

    assign haddr_m_s   = haddr[int'(m_r)*ADDR_BUS_WIDTH +: ADDR_BUS_WIDTH];
    assign bc_m_s      = broadcast[int'(m_r)*3 +: 3];
    assign hwdata_m_s  = hwdata[int'(m_r)*LINE_W +: LINE_W];
    assign idx_s       = IDX_W'(addr_r % ADDR_BUS_WIDTH'(MEM_LINES));
    assign mem_we_s    = rst && ((state_r == S_WDATA) ||
                         ((state_r == S_DATA) && (cnt_r == CNT_LAST) && owner_valid_r));
    assign mem_wdata_s = (state_r == S_WDATA) ? hwdata_m_s : owner_data_r;

    // Round-robin pick: first requester at or after the pointer, wrapping.
    always_comb begin
        pick_s  = rr_r;
        cand_s  = rr_r;
        found_s = 1'b0;
        for (int k = 0; k < NUM_CACHES; k++) begin
            cand_s = CW'((int'(rr_r) + k) % NUM_CACHES);
            if (!found_s && hreq[cand_s]) begin
                pick_s  = cand_s;
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Snoop response gathering: peers holding the line and the lowest modified owner.
    always_comb begin
        holders_s   = '0;
        own_found_s = 1'b0;
        own_data_s  = '0;
        for (int i = 0; i < NUM_CACHES; i++) begin
            holders_s[i] = (i != int'(m_r)) && (sc_state[2*i +: 2] != ST_INVALID);
            if ((i != int'(m_r)) && (sc_state[2*i +: 2] == ST_MODIFIED) && !own_found_s) begin
                own_found_s = 1'b1;
                own_data_s  = sdata[i*LINE_W +: LINE_W];
            end else begin
                own_found_s = own_found_s;
            end
        end
    end

    // Line memory: survives reset, written by flushes and by owner write-back.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[idx_s] <= mem_wdata_s;
        end
    end

    // Bus transaction sequencer with registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r       <= S_IDLE;
            m_r           <= '0;
            rr_r          <= '0;
            addr_r        <= '0;
            bc_r          <= 3'd0;
            isl_r         <= 1'b0;
            owner_valid_r <= 1'b0;
            owner_data_r  <= '0;
            cnt_r         <= '0;
            hgrant        <= '0;
            hready        <= '0;
            hrdata        <= '0;
            other_copies  <= '0;
            snoop_valid   <= '0;
            saddr         <= '0;
            sn_state      <= ST_INVALID;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (found_s) begin
                        m_r     <= pick_s;
                        hgrant  <= onehot(pick_s);
                        state_r <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    hready  <= onehot(m_r);
                    state_r <= S_ADDR;
                end
                S_ADDR: begin
                    hready        <= '0;
                    addr_r        <= haddr_m_s;
                    bc_r          <= bc_m_s;
                    isl_r         <= 1'b0;
                    owner_valid_r <= 1'b0;
                    cnt_r         <= '0;
                    if (hwrite[m_r]) begin
                        state_r <= S_WDATA;
                    end else if ((bc_m_s == BC_RD) || (bc_m_s == BC_RTM) || (bc_m_s == BC_IVD)) begin
                        snoop_valid <= ~onehot(m_r);
                        saddr       <= haddr_m_s;
                        sn_state    <= (bc_m_s == BC_RD) ? ST_SHARED : ST_INVALID;
                        state_r     <= S_SNOOP;
                    end else if (bc_m_s == BC_ISL) begin
                        // Bare ISL: acknowledge and wait for the follow-up read phase.
                        isl_r   <= 1'b1;
                        hready  <= onehot(m_r);
                        state_r <= S_RESP;
                    end else begin
                        state_r <= S_DATA;
                    end
                end
                S_SNOOP: begin
                    snoop_valid   <= '0;
                    other_copies  <= (|holders_s) ? onehot(m_r) : '0;
                    owner_valid_r <= own_found_s;
                    owner_data_r  <= own_data_s;
                    if (bc_r == BC_IVD) begin
                        hready  <= onehot(m_r);
                        state_r <= S_RESP;
                    end else begin
                        state_r <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (cnt_r == CNT_LAST) begin
                        hrdata  <= owner_valid_r ? owner_data_r : mem_r[idx_s];
                        hready  <= onehot(m_r);
                        state_r <= S_RESP;
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                S_WDATA: begin
                    hready  <= onehot(m_r);
                    state_r <= S_RESP;
                end
                S_RESP: begin
                    hready       <= '0;
                    other_copies <= '0;
                    if (isl_r && hreq[m_r]) begin
                        isl_r   <= 1'b0;
                        state_r <= S_ADDR;
                    end else begin
                        hgrant  <= '0;
                        rr_r    <= (m_r == CW'(NUM_CACHES - 1)) ? '0 : m_r + 1'b1;
                        state_r <= S_IDLE;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Self-checking bench for coherence_bus_ctrl: reads, snoops, intervention,
// flushes, round-robin contention and reset in the middle of a data phase.
module tb_coherence_bus_ctrl;

    localparam int N   = 2;
    localparam int AW  = 32;
    localparam int LW  = 32;
    localparam int LAT = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N-1:0]    hreq = '0;
    logic [N-1:0]    hgrant;
    logic [N-1:0]    hready;
    logic [N*AW-1:0] haddr = '0;
    logic [N-1:0]    hwrite = '0;
    logic [N*LW-1:0] hwdata = '0;
    logic [LW-1:0]   hrdata;
    logic [N*3-1:0]  broadcast = '0;
    logic [N-1:0]    other_copies;
    logic [N-1:0]    snoop_valid;
    logic [AW-1:0]   saddr;
    logic [1:0]      sn_state;
    logic [N*2-1:0]  sc_state = '0;
    logic [N*LW-1:0] sdata = '0;

    int checks = 0;
    int errors = 0;
    logic [LW-1:0] exp_q[$];
    logic [LW-1:0] mdl[int];

    coherence_bus_ctrl #(
        .NUM_CACHES(N), .ADDR_BUS_WIDTH(AW), .LOG2_LINE_SIZE(2),
        .MEM_LINES(256), .MEM_LAT(LAT)
    ) dut (
        .clk(clk), .rst(rst), .hreq(hreq), .hgrant(hgrant), .hready(hready),
        .haddr(haddr), .hwrite(hwrite), .hwdata(hwdata), .hrdata(hrdata),
        .broadcast(broadcast), .other_copies(other_copies),
        .snoop_valid(snoop_valid), .saddr(saddr), .sn_state(sn_state),
        .sc_state(sc_state), .sdata(sdata)
    );

    always #5 clk = ~clk;

    function automatic int idx(input logic [31:0] a);
        return int'(a % 32'd256);
    endfunction

    // Drive one transaction from cache c and report what the DUT produced.
    task automatic run_txn(input int c, input logic [31:0] a, input logic w,
                           input logic [2:0] bc, input logic [31:0] wd,
                           output logic [31:0] rd, output logic [1:0] oc,
                           output int lat, output logic [1:0] snv,
                           output logic [1:0] sns, output logic to);
        int hr;
        hr = 0; rd = '0; oc = '0; lat = 0; snv = '0; sns = '0; to = 1'b1;
        haddr[c*AW +: AW] = a;
        hwrite[c] = w;
        broadcast[c*3 +: 3] = bc;
        hwdata[c*LW +: LW] = wd;
        hreq[c] = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            lat++;
            if (snoop_valid != 2'b00) begin
                snv = snoop_valid;
                sns = sn_state;
            end
            if (hready[c]) hr++;
            if (hr == 2) begin
                rd = hrdata;
                oc = other_copies;
                to = 1'b0;
                break;
            end
        end
        hreq[c] = 1'b0;
        hwrite[c] = 1'b0;
        broadcast[c*3 +: 3] = 3'd0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        checks++;
        if ({hgrant, hready, other_copies, snoop_valid} !== 8'h00) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 00000000", {hgrant, hready, other_copies, snoop_valid});
        end
        checks++;
        if (hrdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_hrdata: got %h required 00000000", hrdata);
        end
        checks++;
        if ({saddr, sn_state} !== 34'h0) begin
            errors++;
            $display("FAIL reset_saddr_sn: got %h/%0d required 0/0", saddr, sn_state);
        end
    endtask

    task automatic test_single_read();
        logic [31:0] rd; logic [1:0] oc, snv, sns; int lat; logic to;
        run_txn(0, 32'h10, 1'b1, 3'd0, 32'hAABBCCDD, rd, oc, lat, snv, sns, to);
        mdl[idx(32'h10)] = 32'hAABBCCDD;
        checks++;
        if (to !== 1'b0 || lat !== 4) begin
            errors++;
            $display("FAIL write_latency: got %0d (timeout %b) required 4", lat, to);
        end
        // Requester's own state must not count as a peer copy.
        sc_state = {2'd0, 2'd2};
        exp_q.push_back(mdl[idx(32'h10)]);
        run_txn(0, 32'h10, 1'b0, 3'd1, 32'h0, rd, oc, lat, snv, sns, to);
        checks++;
        if (rd !== exp_q.pop_front()) begin
            errors++;
            $display("FAIL single_read_data: got %h required aabbccdd", rd);
        end
        checks++;
        if (oc !== 2'b00) begin
            errors++;
            $display("FAIL single_read_oc: got %b required 00", oc);
        end
        checks++;
        if (to !== 1'b0 || lat !== 4 + LAT) begin
            errors++;
            $display("FAIL single_read_latency: got %0d required %0d", lat, 4 + LAT);
        end
        sc_state = '0;
    endtask

    task automatic test_shared_read();
        logic [31:0] rd; logic [1:0] oc, snv, sns; int lat; logic to;
        sc_state = {2'd2, 2'd0};
        exp_q.push_back(mdl[idx(32'h10)]);
        run_txn(0, 32'h10, 1'b0, 3'd1, 32'h0, rd, oc, lat, snv, sns, to);
        checks++;
        if (snv !== 2'b10 || sns !== 2'd1) begin
            errors++;
            $display("FAIL shared_snoop: got valid %b state %0d required 10/1", snv, sns);
        end
        checks++;
        if (oc !== 2'b01) begin
            errors++;
            $display("FAIL shared_oc: got %b required 01", oc);
        end
        checks++;
        if (rd !== exp_q.pop_front()) begin
            errors++;
            $display("FAIL shared_data: got %h required aabbccdd", rd);
        end
        sc_state = '0;
    endtask

    task automatic test_modified();
        logic [31:0] rd; logic [1:0] oc, snv, sns; int lat; logic to;
        sc_state = {2'd3, 2'd0};
        sdata = {32'h11223344, 32'h55555555};
        exp_q.push_back(32'h11223344);
        mdl[idx(32'h10)] = 32'h11223344;
        run_txn(0, 32'h10, 1'b0, 3'd2, 32'h0, rd, oc, lat, snv, sns, to);
        checks++;
        if (rd !== exp_q.pop_front()) begin
            errors++;
            $display("FAIL rtm_data: got %h required 11223344", rd);
        end
        checks++;
        if (sns !== 2'd0 || snv !== 2'b10 || oc !== 2'b01) begin
            errors++;
            $display("FAIL rtm_snoop: got state %0d valid %b oc %b required 0/10/01", sns, snv, oc);
        end
        sc_state = '0;
        sdata = '0;
        exp_q.push_back(mdl[idx(32'h10)]);
        run_txn(0, 32'h10, 1'b0, 3'd0, 32'h0, rd, oc, lat, snv, sns, to);
        checks++;
        if (rd !== exp_q.pop_front()) begin
            errors++;
            $display("FAIL writeback: got %h required 11223344", rd);
        end
    endtask

    task automatic test_flush_read();
        logic [31:0] rd; logic [1:0] oc, snv, sns; int lat; logic to;
        run_txn(0, 32'h20, 1'b1, 3'd0, 32'hDEADBEEF, rd, oc, lat, snv, sns, to);
        mdl[idx(32'h20)] = 32'hDEADBEEF;
        checks++;
        if (snv !== 2'b00 || to !== 1'b0) begin
            errors++;
            $display("FAIL flush_no_snoop: got %b required 00", snv);
        end
        exp_q.push_back(mdl[idx(32'h20)]);
        run_txn(0, 32'h20, 1'b0, 3'd0, 32'h0, rd, oc, lat, snv, sns, to);
        checks++;
        if (rd !== exp_q.pop_front()) begin
            errors++;
            $display("FAIL flush_read: got %h required deadbeef", rd);
        end
        // Upper address bits are ignored: 0x120 aliases line 0x20.
        exp_q.push_back(mdl[idx(32'h120)]);
        run_txn(1, 32'h120, 1'b0, 3'd0, 32'h0, rd, oc, lat, snv, sns, to);
        checks++;
        if (rd !== exp_q.pop_front()) begin
            errors++;
            $display("FAIL index_wrap: got %h required deadbeef", rd);
        end
    endtask

    task automatic test_contention();
        int order[$];
        int hr, nresp;
        logic [N-1:0] prev_g;
        logic both;
        logic [31:0] rd; logic [1:0] oc, snv, sns; int lat; logic to;
        hr = 0; nresp = 0; prev_g = '0; both = 1'b0;
        haddr = {32'h10, 32'h20};
        broadcast = '0;
        hreq = 2'b11;
        for (int k = 0; k < 80 && nresp < 4; k++) begin
            @(posedge clk); #1;
            if (hgrant == 2'b11) both = 1'b1;
            if (hgrant != 2'b00 && prev_g == 2'b00) begin
                order.push_back(hgrant[1] ? 1 : 0);
                exp_q.push_back(hgrant[1] ? mdl[idx(32'h10)] : mdl[idx(32'h20)]);
                hr = 0;
            end
            prev_g = hgrant;
            if (hready != 2'b00) hr++;
            if (hr == 2) begin
                hr = 0;
                nresp++;
                if (nresp == 4) hreq = 2'b00;
                checks++;
                if (exp_q.size() == 0 || hrdata !== exp_q[0]) begin
                    errors++;
                    $display("FAIL contention_data: got %h response %0d", hrdata, nresp);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
        end
        hreq = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (order.size() != 4 || order[0] != 0 || order[1] != 1 || order[2] != 0 || order[3] != 1) begin
            errors++;
            $display("FAIL rr_order: got %p required 0 1 0 1", order);
        end
        checks++;
        if (both !== 1'b0) begin
            errors++;
            $display("FAIL one_grant: got double grant required one-hot");
        end
        sc_state = {2'd0, 2'd1};
        run_txn(1, 32'h10, 1'b0, 3'd3, 32'h0, rd, oc, lat, snv, sns, to);
        checks++;
        if (snv !== 2'b01 || sns !== 2'd0) begin
            errors++;
            $display("FAIL ivdate_snoop: got valid %b state %0d required 01/0", snv, sns);
        end
        checks++;
        if (to !== 1'b0 || lat !== 4 || oc !== 2'b10) begin
            errors++;
            $display("FAIL ivdate_resp: got lat %0d oc %b required 4/10", lat, oc);
        end
        sc_state = '0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic [1:0] oc, snv, sns; int lat; logic to;
        int hr;
        logic got_g;
        // Leave the pointer at 1, then interrupt cache1 in its data phase.
        run_txn(0, 32'h20, 1'b0, 3'd0, 32'h0, rd, oc, lat, snv, sns, to);
        haddr[AW +: AW] = 32'h10;
        hreq[1] = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({hgrant, hready, other_copies, snoop_valid, sn_state} !== 10'h0 || hrdata !== 32'h0 || saddr !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got %b %h required all zero", {hgrant, hready, other_copies, snoop_valid, sn_state}, hrdata);
        end
        rst = 1'b1;
        haddr = {32'h10, 32'h20};
        hreq = 2'b11;
        got_g = 1'b0;
        for (int k = 0; k < 10 && !got_g; k++) begin
            @(posedge clk); #1;
            if (hgrant != 2'b00) got_g = 1'b1;
        end
        checks++;
        if (hgrant !== 2'b01) begin
            errors++;
            $display("FAIL reset_rr: got grant %b required 01", hgrant);
        end
        hreq[1] = 1'b0;
        exp_q.push_back(mdl[idx(32'h20)]);
        hr = 0;
        for (int k = 0; k < 20 && hr < 2; k++) begin
            @(posedge clk); #1;
            if (hready[0]) hr++;
        end
        checks++;
        if (hr != 2 || hrdata !== exp_q.pop_front()) begin
            errors++;
            $display("FAIL reset_mem_kept: got %h required deadbeef", hrdata);
        end
        hreq = 2'b00;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        test_single_read();
        test_shared_read();
        test_modified();
        test_flush_read();
        test_contention();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
